// File: rtl/dbus_master.sv
// dbus_master: requesting-master side of the dgrant/dbusy_n/dbus_enb handshake.
// Raises dreq, waits for a one-cycle grant, waits for the bus to be released
// and stable for SETTLE_CYC samples, then drives dbus_enb for len+1 beats.
// A shared timeout spanning REQ/WAIT_IDLE/SETTLE aborts with a one-cycle err.
module dbus_master #(
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned SETTLE_CYC = 2,   // legal 1..15
  parameter int unsigned TIMEOUT    = 16   // legal 2..255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             dreq,
  input  logic             dgrant,
  input  logic             dbusy_n,
  output logic             dbus_enb,
  output logic             done,
  output logic             err
);

  localparam int unsigned TmoW = 8;
  localparam int unsigned SetW = 4;

  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  // Parking value once the timeout cycle has passed on a forward transition;
  // it can never equal TmoLast again, so a late grant/settle cannot abort.
  localparam logic [TmoW-1:0] TmoSat  = TmoW'(TIMEOUT);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYC);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitIdle,
    StSettle,
    StXfer,
    StDone,
    StErr
  } state_e;

  state_e          state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [SetW-1:0]  settle_q, settle_d;

  logic            tmo_hit;
  logic [TmoW-1:0] tmo_inc;
  logic            settle_final;

  logic busy_q, dreq_q, enb_q, done_q, err_q;

  assign tmo_hit      = (tmo_q == TmoLast);
  assign tmo_inc      = (tmo_q == TmoSat) ? tmo_q : tmo_q + TmoW'(1);
  assign settle_final = dbusy_n && ((settle_q + SetW'(1)) == SetLast);

  // Next-state logic; forward progress always wins over the timeout.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    settle_d = settle_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StReq;
          len_d    = len;
          tmo_d    = '0;
          settle_d = '0;
        end
      end
      StReq: begin
        tmo_d = tmo_inc;
        if (dgrant) begin
          state_d = StWaitIdle;
        end else if (tmo_hit) begin
          state_d = StErr;
        end
      end
      StWaitIdle: begin
        tmo_d    = tmo_inc;
        settle_d = '0;
        if (dbusy_n) begin
          if (SETTLE_CYC == 1) begin
            state_d = StXfer;
            beat_d  = len_q;
          end else begin
            state_d  = StSettle;
            settle_d = SetW'(1);
          end
        end else if (tmo_hit) begin
          state_d = StErr;
        end
      end
      StSettle: begin
        tmo_d = tmo_inc;
        if (settle_final) begin
          state_d = StXfer;
          beat_d  = len_q;
        end else if (tmo_hit) begin
          state_d = StErr;
        end else if (dbusy_n) begin
          settle_d = settle_q + SetW'(1);
        end else begin
          // Glitch low: restart the settle window.
          state_d  = StWaitIdle;
          settle_d = '0;
        end
      end
      StXfer: begin
        if (beat_q == '0) begin
          state_d = StDone;
        end else begin
          beat_d = beat_q - LEN_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      dreq_q   <= 1'b0;
      enb_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      settle_q <= settle_d;
      busy_q   <= (state_d != StIdle);
      dreq_q   <= (state_d == StReq);
      enb_q    <= (state_d == StXfer);
      done_q   <= (state_d == StDone);
      err_q    <= (state_d == StErr);
    end
  end

  assign busy     = busy_q;
  assign dreq     = dreq_q;
  assign dbus_enb = enb_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dbus_master.sv
// Bench for dbus_master: each scenario pushes the expected per-cycle output
// vector {busy,dreq,dbus_enb,done,err} into a queue, then drives stimulus and
// pops/compares one entry per cycle. Cycle n is the interval after edge n.
module tb_dbus_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       busy, dreq, dgrant, dbusy_n, dbus_enb, done, err;

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  dbus_master #(
    .LEN_W      (4),
    .SETTLE_CYC (2),
    .TIMEOUT    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .dreq     (dreq),
    .dgrant   (dgrant),
    .dbusy_n  (dbusy_n),
    .dbus_enb (dbus_enb),
    .done     (done),
    .err      (err)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] vec(input logic b, input logic q, input logic e,
                                     input logic d, input logic r);
    return {b, q, e, d, r};
  endfunction

  task automatic test_reset();
    logic [4:0] got, e;
    rst_n = 1'b0; start = 1'b1; dgrant = 1'b1; dbusy_n = 1'b1; len = 4'd5;
    tick();
    for (int c = 0; c < 5; c++) exp_q.push_back(5'b0);
    for (int c = 0; c < 5; c++) begin
      e   = exp_q.pop_front();
      got = {busy, dreq, dbus_enb, done, err};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", c, got, e);
      end
      if (c == 2) begin
        rst_n = 1'b1; start = 1'b0; dgrant = 1'b0; dbusy_n = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_nominal();
    logic [4:0] got, e;
    for (int c = 0; c <= 16; c++)
      exp_q.push_back(vec(c >= 1 && c <= 14, c >= 1 && c <= 3, c >= 10 && c <= 13,
                          c == 14, 1'b0));
    for (int c = 0; c <= 16; c++) begin
      e   = exp_q.pop_front();
      got = {busy, dreq, dbus_enb, done, err};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL nominal cyc=%0d got=%b exp=%b", c, got, e);
      end
      start   = (c == 0);
      len     = 4'd3;
      dgrant  = (c == 3);
      dbusy_n = (c >= 8);
      tick();
    end
    start = 1'b0; dgrant = 1'b0; dbusy_n = 1'b0;
  endtask

  task automatic test_settle_glitch();
    logic [4:0] got, e;
    // dbusy_n: low, then 1,0,1,1 at cycles 4..7, then held high.
    for (int c = 0; c <= 12; c++)
      exp_q.push_back(vec(c >= 1 && c <= 10, c >= 1 && c <= 2, c >= 8 && c <= 9,
                          c == 10, 1'b0));
    for (int c = 0; c <= 12; c++) begin
      e   = exp_q.pop_front();
      got = {busy, dreq, dbus_enb, done, err};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL settle_glitch cyc=%0d got=%b exp=%b", c, got, e);
      end
      start   = (c == 0);
      len     = 4'd1;
      dgrant  = (c == 2);
      dbusy_n = (c == 4) || (c >= 6);
      tick();
    end
    start = 1'b0; dgrant = 1'b0; dbusy_n = 1'b0;
  endtask

  task automatic test_grant_timeout();
    logic [4:0] got, e;
    // REQ entered at cycle 1; err 16 cycles later.
    for (int c = 0; c <= 20; c++)
      exp_q.push_back(vec(c >= 1 && c <= 17, c >= 1 && c <= 16, 1'b0, 1'b0, c == 17));
    for (int c = 0; c <= 20; c++) begin
      e   = exp_q.pop_front();
      got = {busy, dreq, dbus_enb, done, err};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL grant_timeout cyc=%0d got=%b exp=%b", c, got, e);
      end
      start   = (c == 0);
      len     = 4'd2;
      dgrant  = 1'b0;
      dbusy_n = 1'b1;
      tick();
    end
    dbusy_n = 1'b0;
  endtask

  task automatic test_coincident();
    logic [4:0] got, e;
    // Grant in cycle 16, when the counter sits at TIMEOUT-1.
    for (int c = 0; c <= 23; c++)
      exp_q.push_back(vec(c >= 1 && c <= 20, c >= 1 && c <= 16, c == 19, c == 20, 1'b0));
    for (int c = 0; c <= 23; c++) begin
      e   = exp_q.pop_front();
      got = {busy, dreq, dbus_enb, done, err};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL coincident cyc=%0d got=%b exp=%b", c, got, e);
      end
      start   = (c == 0);
      len     = 4'd0;
      dgrant  = (c == 16);
      dbusy_n = 1'b1;
      tick();
    end
    dgrant = 1'b0; dbusy_n = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    logic [4:0] got, e;
    // len=7 enb from cycle 4; reset sampled at edge 6 (beat 2 is cycle 5).
    // Fresh len=0 transfer started in cycle 8.
    for (int c = 0; c <= 16; c++)
      exp_q.push_back(vec((c >= 1 && c <= 5) || (c >= 9 && c <= 13),
                          c == 1 || c == 9,
                          (c >= 4 && c <= 5) || c == 12,
                          c == 13, 1'b0));
    for (int c = 0; c <= 16; c++) begin
      e   = exp_q.pop_front();
      got = {busy, dreq, dbus_enb, done, err};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_mid_xfer cyc=%0d got=%b exp=%b", c, got, e);
      end
      rst_n   = (c != 5);
      start   = (c == 0) || (c == 8);
      len     = (c < 8) ? 4'd7 : 4'd0;
      dgrant  = (c == 1) || (c == 9);
      dbusy_n = 1'b1;
      tick();
    end
    rst_n = 1'b1; start = 1'b0; dgrant = 1'b0; dbusy_n = 1'b0;
  endtask

  task automatic test_ignored();
    logic [4:0] got, e;
    // Stray grants in IDLE/XFER/DONE, starts during XFER and DONE.
    for (int c = 0; c <= 14; c++)
      exp_q.push_back(vec(c >= 3 && c <= 9, c == 3, c >= 6 && c <= 8, c == 9, 1'b0));
    for (int c = 0; c <= 14; c++) begin
      e   = exp_q.pop_front();
      got = {busy, dreq, dbus_enb, done, err};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL ignored cyc=%0d got=%b exp=%b", c, got, e);
      end
      start   = (c == 2) || (c == 6) || (c == 7) || (c == 9);
      len     = (c == 2) ? 4'd2 : 4'd9;
      dgrant  = (c == 0) || (c == 1) || (c == 3) || (c == 7) || (c == 9);
      dbusy_n = 1'b1;
      tick();
    end
    start = 1'b0; dgrant = 1'b0; dbusy_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; dgrant = 1'b0; dbusy_n = 1'b0;
    test_reset();
    test_nominal();
    test_settle_glitch();
    test_grant_timeout();
    test_coincident();
    test_reset_mid_xfer();
    test_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_master.md
Name: dbus_master

Overview:
- Requesting-master end of the dgrant/dbusy_n/dbus_enb bus handshake.
- On a local start pulse it:
  - raises dreq;
  - waits for the arbiter's single-cycle dgrant;
  - waits for the previous owner to release the bus (dbusy_n high, stable);
  - drives dbus_enb for a programmed number of beats.
- Reports done on completion, or err if grant/release does not arrive within a timeout.
- Drives the signals the m9_9 assertion checker observes; sits between a local transfer engine and the shared data bus.

Parameters:
- LEN_W, 4: width of len input; beats per transfer = len+1 (1..2**LEN_W).
- SETTLE_CYC, 2: consecutive cycles dbusy_n must be sampled high before dbus_enb rises (legal 1..15).
- TIMEOUT, 16: maximum cycles spent in REQ+WAIT_IDLE+SETTLE before abort (legal 2..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a transfer; honoured only in IDLE.
- len  in  LEN_W  beats minus one; captured when start is accepted.
- busy  out  1  high whenever state != IDLE.
- dreq  out  1  bus request to arbiter.
- dgrant  in  1  single-cycle grant pulse from arbiter.
- dbusy_n  in  1  low = bus still owned by previous master.
- dbus_enb  out  1  bus drive enable, one cycle per beat.
- done  out  1  one-cycle pulse, transfer completed.
- err  out  1  one-cycle pulse, timeout abort.

Behaviour:
- Reset:
  - rst_n sampled low at a clk edge forces state=IDLE and clears all counters.
  - All outputs (busy, dreq, dbus_enb, done, err) are 0 in the following cycle.
  - Applies from any state, including mid-XFER; the transfer is abandoned with no done/err.
- All outputs are registered; no combinational input-to-output paths.

State machine (IDLE, REQ, WAIT_IDLE, SETTLE, XFER, DONE, ERR):
- IDLE:
  - start=1 -> REQ; len latched into len_q; timeout counter cleared.
  - Outputs all 0.
- REQ:
  - dreq=1, busy=1; timeout counter increments each cycle.
  - dgrant=1 -> WAIT_IDLE; dreq is 0 from the next cycle.
- WAIT_IDLE:
  - Waits for dbusy_n=1.
  - Sampled 1 with SETTLE_CYC=1 -> XFER.
  - Sampled 1 with SETTLE_CYC>1 -> SETTLE with settle count=1.
- SETTLE:
  - Each cycle dbusy_n=1 increments settle count; when count reaches SETTLE_CYC -> XFER.
  - dbusy_n=0 -> WAIT_IDLE, settle count cleared (glitch restarts the settle window).
- Timeout:
  - Counter runs across REQ, WAIT_IDLE and SETTLE and is not reset between them.
  - When the counter equals TIMEOUT-1 and that cycle's forward transition is not taken -> ERR.
  - If the forward transition (dgrant in REQ, final settle sample) coincides with the timeout cycle, the forward transition wins.
- Timing: the first edge sampling dbusy_n=1 is edge k. With SETTLE_CYC=2, dbus_enb is high in the cycle after edge k+1, i.e. 2 cycles after dbusy_n rose.
- XFER:
  - dbus_enb=1 for exactly len_q+1 consecutive cycles; beat counter counts down from len_q.
  - dbusy_n is ignored (we own the bus).
  - Last beat -> DONE.
- DONE: done=1 for one cycle, dbus_enb=0 -> IDLE.
- ERR: err=1 for one cycle, dreq=0 -> IDLE.
- Ignored inputs:
  - dgrant outside REQ (no effect, no error).
  - start outside IDLE.
  - start in the DONE/ERR cycle (it is not queued).
- Invariants:
  - dreq and dbus_enb are never high together.
  - done and err are never high together.
  - busy = (state != IDLE).

Test Plan:
- Nominal, len=3, SETTLE_CYC=2:
  - Stimulus: start at cycle 0; dgrant pulse at cycle 3; dbusy_n rises at cycle 8.
  - Response: dreq high cycles 1..3.
  - Response: dbus_enb high cycles 10..13 (4 beats).
  - Response: done pulse at cycle 14; busy low at cycle 15.
- Settle glitch:
  - Stimulus: after grant, dbusy_n pattern 1,0,1,1.
  - Response: dbus_enb rises only after the second consecutive high sample; no early enable.
- Grant timeout, TIMEOUT=16:
  - Stimulus: start; never assert dgrant.
  - Response: err pulse exactly 16 cycles after entering REQ; dreq low thereafter; dbus_enb never asserted.
- Coincident dgrant and timeout:
  - Stimulus: dgrant arrives when the counter equals 15.
  - Response: WAIT_IDLE taken; no err.
- Reset mid-XFER:
  - Stimulus: rst_n low on beat 2 of len=7.
  - Response: dbus_enb=0 next cycle; no done/err; fresh start accepted afterwards.
- Ignored inputs:
  - Stimulus: stray dgrant in IDLE; start during XFER.
  - Response: no state change; only one done pulse for the single accepted transfer.
